// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger conditioner: FSM encoding, trig_cfg and
// trig_sts bit positions, and the saturating event-counter increment.
package trigger_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_FOLLOW   = 2'd3
    } trig_state_e;

    // trig_cfg bit positions (bits 7:4 are reserved and ignored)
    localparam int CFG_ENABLE   = 0;
    localparam int CFG_POLARITY = 1;
    localparam int CFG_MODE     = 2;
    localparam int CFG_SW_TRIG  = 3;

    // trig_sts bit positions (bits 1:0 carry the FSM state)
    localparam int STS_SYNC_LEVEL = 2;
    localparam int STS_DEB_LEVEL  = 3;

    // Event counter increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Debounce filter: the output level follows 'act' only after act has
// differed from it for threshold+1 consecutive cycles. 'level_next' is the
// value the level takes at the next edge; 'rise' is a registered strobe that
// is high for the first cycle the level reads 1.
module debounce_filter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         act,
    input  logic [W-1:0] threshold,
    output logic         level,
    output logic         level_next,
    output logic         rise
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         level_q, level_d;
    logic         rise_q, rise_d;

    // Count cycles of disagreement; the live threshold is compared every cycle
    // so a lowered threshold flips the level on the very next edge.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (act == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= threshold) begin
            level_d = act;
            cnt_d   = '0;
        end else if (cnt_q != {W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = level_d & ~level_q;
    end

    // Filter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level      = level_q;
    assign level_next = level_d;
    assign rise       = rise_q;

endmodule

// File: rtl/trigger_conditioner.sv
// Trigger conditioner: synchronises and debounces an external trigger pin,
// applies polarity, and runs a one-shot / follow FSM that drives the reset
// manager trigger, a per-event strobe and a saturating event counter.
// Handshake-free: all outputs are registered levels/strobes on clk.
module trigger_conditioner
    import trigger_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic                  clk,
    input  logic                  peripheral_aresetn,
    input  logic                  trigger_raw,
    input  logic [DEBOUNCE_W-1:0] debounce_cycles,
    input  logic [7:0]            trig_cfg,
    output logic                  trigger_out,
    output logic                  trigger_pulse,
    output logic [31:0]           trigger_count,
    output logic [7:0]            trig_sts
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    trig_state_e            state_q, state_d;
    logic                   out_q, out_d;
    logic                   pulse_q, pulse_d;
    logic [31:0]            count_q, count_d;
    logic                   en_prev_q, sw_prev_q;

    logic sync_level, act;
    logic deb_level, deb_level_next, deb_rise;
    logic en, en_rise, sw_rise;
    logic unused_cfg;

    assign unused_cfg = ^trig_cfg[7:4];

    // Shift the raw pin into the synchroniser chain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], trigger_raw};
    end

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign act        = sync_level ^ trig_cfg[CFG_POLARITY];

    debounce_filter #(
        .W (DEBOUNCE_W)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (peripheral_aresetn),
        .act        (act),
        .threshold  (debounce_cycles),
        .level      (deb_level),
        .level_next (deb_level_next),
        .rise       (deb_rise)
    );

    assign en      = trig_cfg[CFG_ENABLE];
    assign en_rise = en & ~en_prev_q;
    assign sw_rise = trig_cfg[CFG_SW_TRIG] & ~sw_prev_q;

    // FSM next state; mode is only sampled on the enable rising edge, so a
    // mode change while enabled has no effect until enable is cycled.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pulse_d = 1'b0;
        count_d = count_q;
        if (!en) begin
            state_d = ST_DISARMED;
            out_d   = 1'b0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    out_d = 1'b0;
                    if (en_rise) begin
                        state_d = trig_cfg[CFG_MODE] ? ST_ARMED : ST_FOLLOW;
                        count_d = '0;
                    end
                end
                ST_ARMED: begin
                    out_d = 1'b0;
                    // hw and sw edges together still make a single event
                    if (deb_rise || sw_rise) begin
                        state_d = ST_ACTIVE;
                        out_d   = 1'b1;
                        pulse_d = 1'b1;
                        count_d = sat_inc32(count_q);
                    end
                end
                ST_ACTIVE: begin
                    out_d = 1'b1;
                end
                ST_FOLLOW: begin
                    out_d = deb_level_next | trig_cfg[CFG_SW_TRIG];
                    if (out_d && !out_q) begin
                        pulse_d = 1'b1;
                        count_d = sat_inc32(count_q);
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    out_d   = 1'b0;
                end
            endcase
        end
    end

    // Synchroniser, edge detectors, FSM state and registered outputs
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            sync_q    <= '0;
            state_q   <= ST_DISARMED;
            out_q     <= 1'b0;
            pulse_q   <= 1'b0;
            count_q   <= '0;
            en_prev_q <= 1'b0;
            sw_prev_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            out_q     <= out_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
            en_prev_q <= en;
            sw_prev_q <= trig_cfg[CFG_SW_TRIG];
        end
    end

    assign trigger_out   = out_q;
    assign trigger_pulse = pulse_q;
    assign trigger_count = count_q;
    assign trig_sts      = {4'b0000, deb_level, sync_level, state_q};

endmodule

// File: tb/tb_trigger_conditioner.sv
// Self-checking bench for trigger_conditioner: directed scenarios with fixed
// expectations plus randomized pin/config traffic checked against a
// behavioural model of the trigger rules.
module tb_trigger_conditioner;

    localparam int SYNC = 2;
    localparam int DW   = 16;

    logic          clk;
    logic          peripheral_aresetn;
    logic          trigger_raw;
    logic [DW-1:0] debounce_cycles;
    logic [7:0]    trig_cfg;
    logic          trigger_out;
    logic          trigger_pulse;
    logic [31:0]   trigger_count;
    logic [7:0]    trig_sts;

    int n_checks;
    int n_fails;

    trigger_conditioner #(
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_W  (DW)
    ) dut (
        .clk                (clk),
        .peripheral_aresetn (peripheral_aresetn),
        .trigger_raw        (trigger_raw),
        .debounce_cycles    (debounce_cycles),
        .trig_cfg           (trig_cfg),
        .trigger_out        (trigger_out),
        .trigger_pulse      (trigger_pulse),
        .trigger_count      (trigger_count),
        .trig_sts           (trig_sts)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with the given config held, then release; the release edge is
    // consumed so an enabled DUT is already ARMED/FOLLOW on return.
    task automatic reset_dut(input logic [7:0] cfg, input int thr, input logic raw);
        trig_cfg           = cfg;
        debounce_cycles    = DW'(thr);
        trigger_raw        = raw;
        peripheral_aresetn = 1'b0;
        repeat (3) tick();
        peripheral_aresetn = 1'b1;
        tick();
    endtask

    // ---------------- behavioural model ----------------
    logic        m_pipe[$];
    logic        m_level;
    int          m_run;
    logic        m_rise;
    int          m_state;
    logic        m_out;
    logic        m_pulse;
    logic [31:0] m_count;
    logic        m_en_prev;
    logic        m_sw_prev;

    task automatic m_reset();
        m_pipe = {};
        for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
        m_level = 0; m_run = 0; m_rise = 0; m_state = 0;
        m_out = 0; m_pulse = 0; m_count = 0; m_en_prev = 0; m_sw_prev = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic m_step();
        logic act, lvl, en, sw, sw_edge, en_edge, out_n, pulse_n;
        int   run, st_n;
        logic [31:0] cnt_n;
        act = m_pipe[0] ^ trig_cfg[1];
        // level changes once act has disagreed for threshold+1 cycles in a row
        run = (act != m_level) ? m_run + 1 : 0;
        lvl = m_level;
        if (run > 0 && run >= int'(debounce_cycles) + 1) begin
            lvl = act;
            run = 0;
        end
        en      = trig_cfg[0];
        sw      = trig_cfg[3];
        sw_edge = sw && !m_sw_prev;
        en_edge = en && !m_en_prev;
        st_n = m_state; out_n = m_out; pulse_n = 0; cnt_n = m_count;
        if (!en) begin
            st_n = 0; out_n = 0;
        end else if (m_state == 0) begin
            out_n = 0;
            if (en_edge) begin
                st_n  = trig_cfg[2] ? 1 : 3;
                cnt_n = 0;
            end
        end else if (m_state == 1) begin
            out_n = 0;
            if (m_rise || sw_edge) begin
                st_n = 2; out_n = 1; pulse_n = 1;
                if (cnt_n != 32'hFFFF_FFFF) cnt_n++;
            end
        end else if (m_state == 2) begin
            out_n = 1;
        end else begin
            out_n = lvl | sw;
            if (out_n && !m_out) begin
                pulse_n = 1;
                if (cnt_n != 32'hFFFF_FFFF) cnt_n++;
            end
        end
        m_rise    = lvl && !m_level;
        m_level   = lvl;
        m_run     = run;
        m_state   = st_n;
        m_out     = out_n;
        m_pulse   = pulse_n;
        m_count   = cnt_n;
        m_en_prev = en;
        m_sw_prev = sw;
        void'(m_pipe.pop_front());
        m_pipe.push_back(trigger_raw);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        trig_cfg = 8'h00; debounce_cycles = '0; trigger_raw = 1'b1;
        peripheral_aresetn = 1'b0;
        #1;
        n_checks++;
        if (trigger_out !== 1'b0 || trigger_pulse !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_out: got out=%b pulse=%b expected 0 0", trigger_out, trigger_pulse);
        end
        n_checks++;
        if (trigger_count !== 32'd0 || trig_sts !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_cnt_sts: got count=%0h sts=%0h expected 0 0", trigger_count, trig_sts);
        end
        tick();
        peripheral_aresetn = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (trig_sts[1:0] !== 2'd0 || trigger_out !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_disabled: got state=%0d out=%b expected 0 0", trig_sts[1:0], trigger_out);
        end
    endtask

    task automatic test_oneshot_pulse();
        int first, pulses, pulse_k;
        reset_dut(8'h05, 10, 1'b0);
        n_checks++;
        if (trig_sts[1:0] !== 2'd1) begin
            n_fails++;
            $display("FAIL oneshot_armed: got state=%0d expected 1", trig_sts[1:0]);
        end
        first = -1; pulses = 0; pulse_k = -1;
        trigger_raw = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 21) trigger_raw = 1'b0;
            tick();
            if (trigger_out === 1'b1 && first < 0) first = k;
            if (trigger_pulse === 1'b1) begin pulses++; pulse_k = k; end
        end
        n_checks++;
        if (first !== 14) begin
            n_fails++;
            $display("FAIL oneshot_latency: got %0d cycles expected 14", first);
        end
        n_checks++;
        if (pulses !== 1 || pulse_k !== 14) begin
            n_fails++;
            $display("FAIL oneshot_pulse: got %0d pulses at %0d expected 1 at 14", pulses, pulse_k);
        end
        n_checks++;
        if (trigger_count !== 32'd1 || trigger_out !== 1'b1) begin
            n_fails++;
            $display("FAIL oneshot_count: got count=%0d out=%b expected 1 1", trigger_count, trigger_out);
        end
    endtask

    task automatic test_glitch();
        logic saw_lvl, saw_out;
        int   pulses;
        reset_dut(8'h05, 10, 1'b0);
        saw_lvl = 0; saw_out = 0; pulses = 0;
        trigger_raw = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 9) trigger_raw = 1'b0;
            tick();
            if (trig_sts[3] === 1'b1) saw_lvl = 1;
            if (trigger_out === 1'b1) saw_out = 1;
            if (trigger_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (saw_lvl !== 1'b0 || saw_out !== 1'b0) begin
            n_fails++;
            $display("FAIL glitch_level: got level_seen=%b out_seen=%b expected 0 0", saw_lvl, saw_out);
        end
        n_checks++;
        if (trigger_count !== 32'd0 || pulses !== 0) begin
            n_fails++;
            $display("FAIL glitch_count: got count=%0d pulses=%0d expected 0 0", trigger_count, pulses);
        end
    endtask

    task automatic test_active_hold();
        int   pulses, waited;
        logic dropped;
        reset_dut(8'h05, 0, 1'b0);
        trigger_raw = 1'b1;
        waited = 0;
        while (trigger_out !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (trigger_out !== 1'b1) begin
            n_fails++;
            $display("FAIL active_reach: got out=%b after %0d cycles expected 1", trigger_out, waited);
        end
        pulses = 0; dropped = 0;
        for (int k = 0; k < 40; k++) begin
            trigger_raw = 1'($urandom_range(0, 1));
            trig_cfg[3] = 1'($urandom_range(0, 1));
            tick();
            if (trigger_pulse === 1'b1) pulses++;
            if (trigger_out !== 1'b1) dropped = 1;
        end
        n_checks++;
        if (pulses !== 0 || dropped !== 1'b0 || trigger_count !== 32'd1) begin
            n_fails++;
            $display("FAIL active_hold: got pulses=%0d dropped=%b count=%0d expected 0 0 1",
                     pulses, dropped, trigger_count);
        end
        trig_cfg = 8'h00;
        tick();
        n_checks++;
        if (trigger_out !== 1'b0 || trig_sts[1:0] !== 2'd0) begin
            n_fails++;
            $display("FAIL active_disable: got out=%b state=%0d expected 0 0", trigger_out, trig_sts[1:0]);
        end
    endtask

    task automatic test_follow_polarity();
        int first_hi, first_lo, pulses;
        reset_dut(8'h03, 3, 1'b1);
        repeat (10) tick();
        n_checks++;
        if (trigger_out !== 1'b0 || trig_sts[1:0] !== 2'd3) begin
            n_fails++;
            $display("FAIL follow_idle: got out=%b state=%0d expected 0 3", trigger_out, trig_sts[1:0]);
        end
        first_hi = -1; first_lo = -1; pulses = 0;
        trigger_raw = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (trigger_out === 1'b1 && first_hi < 0) first_hi = k;
            if (trigger_pulse === 1'b1) pulses++;
        end
        trigger_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (trigger_out === 1'b0 && first_lo < 0) first_lo = k;
            if (trigger_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (first_hi !== 6 || first_lo !== 6) begin
            n_fails++;
            $display("FAIL follow_latency: got rise=%0d fall=%0d expected 6 6", first_hi, first_lo);
        end
        n_checks++;
        if (pulses !== 1 || trigger_count !== 32'd1) begin
            n_fails++;
            $display("FAIL follow_count: got pulses=%0d count=%0d expected 1 1", pulses, trigger_count);
        end
    endtask

    task automatic test_simultaneous();
        reset_dut(8'h05, 0, 1'b0);
        trigger_raw = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (trig_sts[3] !== 1'b1 || trigger_out !== 1'b0) begin
            n_fails++;
            $display("FAIL simul_setup: got level=%b out=%b expected 1 0", trig_sts[3], trigger_out);
        end
        trig_cfg[3] = 1'b1;
        tick();
        n_checks++;
        if (trigger_out !== 1'b1 || trigger_pulse !== 1'b1 || trigger_count !== 32'd1) begin
            n_fails++;
            $display("FAIL simul_edge: got out=%b pulse=%b count=%0d expected 1 1 1",
                     trigger_out, trigger_pulse, trigger_count);
        end
        tick();
        n_checks++;
        if (trigger_pulse !== 1'b0 || trigger_count !== 32'd1) begin
            n_fails++;
            $display("FAIL simul_single: got pulse=%b count=%0d expected 0 1", trigger_pulse, trigger_count);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                reset_dut(8'h05, 10, 1'b0);
                trigger_raw = 1'b1;
                repeat (6) tick();
            end else begin
                reset_dut(8'h05, 0, 1'b0);
                trigger_raw = 1'b1;
                repeat (4) tick();
                n_checks++;
                if (trigger_out !== 1'b1) begin
                    n_fails++;
                    $display("FAIL rstmid_active: got out=%b expected 1", trigger_out);
                end
            end
            peripheral_aresetn = 1'b0;
            #1;
            n_checks++;
            if (trigger_out !== 1'b0 || trigger_pulse !== 1'b0 ||
                trigger_count !== 32'd0 || trig_sts !== 8'h00) begin
                n_fails++;
                $display("FAIL rstmid_clear%0d: got out=%b pulse=%b count=%0d sts=%0h expected all 0",
                         pass, trigger_out, trigger_pulse, trigger_count, trig_sts);
            end
            trigger_raw = 1'b0;
            repeat (2) tick();
            peripheral_aresetn = 1'b1;
            tick();
            n_checks++;
            if (trig_sts !== 8'h01 || trigger_count !== 32'd0) begin
                n_fails++;
                $display("FAIL rstmid_release%0d: got sts=%0h count=%0d expected 01 0",
                         pass, trig_sts, trigger_count);
            end
            pulses = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (trigger_pulse === 1'b1 || trigger_out === 1'b1) pulses++;
            end
            n_checks++;
            if (pulses !== 0) begin
                n_fails++;
                $display("FAIL rstmid_quiet%0d: got %0d active cycles expected 0", pass, pulses);
            end
        end
    endtask

    task automatic test_random();
        int run_left;
        logic [7:0] e_sts;
        for (int r = 0; r < 6; r++) begin
            debounce_cycles = DW'($urandom_range(0, 4));
            trig_cfg = {4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'b1};
            trigger_raw = trig_cfg[1];
            peripheral_aresetn = 1'b0;
            tick();
            m_reset();
            peripheral_aresetn = 1'b1;
            run_left = 0;
            for (int c = 0; c < 300; c++) begin
                if (run_left == 0) begin
                    trigger_raw = ~trigger_raw;
                    run_left = $urandom_range(1, 8);
                end else begin
                    run_left--;
                end
                if ($urandom_range(0, 15) == 0) trig_cfg[3] = ~trig_cfg[3];
                if ($urandom_range(0, 79) == 0) trig_cfg[0] = ~trig_cfg[0];
                if ($urandom_range(0, 59) == 0) trig_cfg[2] = ~trig_cfg[2];
                if ($urandom_range(0, 99) == 0) debounce_cycles = DW'($urandom_range(0, 4));
                m_step();
                tick();
                e_sts = {4'b0000, m_level, m_pipe[0], m_state[1:0]};
                n_checks++;
                if (trigger_out !== m_out || trigger_pulse !== m_pulse) begin
                    n_fails++;
                    $display("FAIL rand_out r%0d c%0d: got out=%b pulse=%b expected %b %b",
                             r, c, trigger_out, trigger_pulse, m_out, m_pulse);
                end
                n_checks++;
                if (trigger_count !== m_count) begin
                    n_fails++;
                    $display("FAIL rand_count r%0d c%0d: got %0d expected %0d", r, c, trigger_count, m_count);
                end
                n_checks++;
                if (trig_sts !== e_sts) begin
                    n_fails++;
                    $display("FAIL rand_sts r%0d c%0d: got %0h expected %0h", r, c, trig_sts, e_sts);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fails  = 0;
        peripheral_aresetn = 1'b0;
        trigger_raw = 1'b0;
        debounce_cycles = '0;
        trig_cfg = 8'h00;
        test_reset();
        test_oneshot_pulse();
        test_glitch();
        test_active_hold();
        test_follow_polarity();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
